// File: rtl/req_grant_arbiter_if.sv
// Request/grant bus between masters and the round-robin arbiter.
interface req_grant_arbiter_if #(
  parameter int unsigned N_REQ = 2
);
  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             busy;
  logic             lat_err;
  logic [ID_W-1:0]  lat_err_id;

  // Requesting side: drives level requests, observes grants and status.
  modport master (
    output req,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  lat_err,
    input  lat_err_id
  );

  // Arbiter side.
  modport slave (
    input  req,
    output gnt,
    output gnt_id,
    output busy,
    output lat_err,
    output lat_err_id
  );
endinterface

// File: rtl/req_grant_arbiter.sv
// Round-robin request/grant arbiter with a fixed arbitration-to-grant delay
// and a per-master latency monitor that raises a sticky error flag.
module req_grant_arbiter #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned GNT_DLY = 2,
  parameter int unsigned MAX_LAT = 5
) (
  input logic                clk,
  input logic                rst,
  req_grant_arbiter_if.slave bus
);

  localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(GNT_DLY + 1);
  localparam int unsigned AGE_W = $clog2(MAX_LAT + 2);

  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GNT_DLY - 1);
  localparam logic [AGE_W-1:0] AGE_LIM  = AGE_W'(MAX_LAT);
  localparam logic [AGE_W-1:0] AGE_SAT  = AGE_W'(MAX_LAT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_GRANT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ID_W-1:0]  win_q, win_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] excl_q, excl_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic             busy_q, busy_d;
  logic             lat_err_q, lat_err_d;
  logic [ID_W-1:0]  lat_err_id_q, lat_err_id_d;
  logic [AGE_W-1:0] age_q [N_REQ];
  logic [AGE_W-1:0] age_d [N_REQ];

  logic [N_REQ-1:0] cand_c;
  logic             pick_vld_c;
  logic [ID_W-1:0]  pick_id_c;

  // Index after v, wrapping at N_REQ.
  function automatic logic [ID_W-1:0] inc_wrap(input logic [ID_W-1:0] v);
    if (32'(v) == N_REQ - 1) begin
      return '0;
    end
    return v + ID_W'(1);
  endfunction

  // Round-robin search from rr_q upward; the master granted on the previous
  // edge is masked so a held request cannot win twice in a row.
  always_comb begin : rr_pick
    int unsigned idx;
    idx        = 0;
    cand_c     = bus.req & ~excl_q;
    pick_vld_c = 1'b0;
    pick_id_c  = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = 32'(rr_q) + off;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!pick_vld_c && cand_c[ID_W'(idx)]) begin
        pick_vld_c = 1'b1;
        pick_id_c  = ID_W'(idx);
      end
    end
  end

  // Arbitration FSM next-state and grant outputs.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    excl_d   = '0;
    gnt_d    = '0;
    gnt_id_d = gnt_id_q;
    busy_d   = busy_q;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (pick_vld_c) begin
          state_d = ST_WAIT;
          win_d   = pick_id_c;
          cnt_d   = CNT_W'(1);
          busy_d  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!bus.req[win_q]) begin
          // Winner withdrew before its grant: drop the arbitration.
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_GRANT;
          gnt_d    = ONE_HOT0 << win_q;
          gnt_id_d = win_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GRANT: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        rr_d    = inc_wrap(win_q);
        excl_d  = ONE_HOT0 << win_q;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Per-master waiting age and first-violation capture.
  always_comb begin : lat_mon
    logic hit;
    hit          = 1'b0;
    lat_err_d    = lat_err_q;
    lat_err_id_d = lat_err_id_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      age_d[i] = age_q[i];
      if (!bus.req[ID_W'(i)] || gnt_q[ID_W'(i)]) begin
        age_d[i] = '0;
      end else if (age_q[i] != AGE_SAT) begin
        age_d[i] = age_q[i] + AGE_W'(1);
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!lat_err_q && !hit && (age_q[i] == AGE_LIM) && !gnt_q[ID_W'(i)]) begin
        hit          = 1'b1;
        lat_err_d    = 1'b1;
        lat_err_id_d = ID_W'(i);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      win_q        <= '0;
      rr_q         <= '0;
      cnt_q        <= '0;
      excl_q       <= '0;
      gnt_q        <= '0;
      gnt_id_q     <= '0;
      busy_q       <= 1'b0;
      lat_err_q    <= 1'b0;
      lat_err_id_q <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
      excl_q       <= excl_d;
      gnt_q        <= gnt_d;
      gnt_id_q     <= gnt_id_d;
      busy_q       <= busy_d;
      lat_err_q    <= lat_err_d;
      lat_err_id_q <= lat_err_id_d;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.gnt_id     = gnt_id_q;
  assign bus.busy       = busy_q;
  assign bus.lat_err    = lat_err_q;
  assign bus.lat_err_id = lat_err_id_q;

endmodule
